// File: rtl/sweep_pkg.sv
// Shared types and helpers for the truth table sweeper.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sweep_state_t;

    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that spaces vector drive and sample edges.
module sweep_settle_timer
    import sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(SETTLE);
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/response checker for a small combinational DUT.
// Define TRUTH_TABLE_SWEEPER_LOG_EN to expose the measured table on obs_table.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int                      N_IN   = 3,
    parameter int                      SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]    EXPECT = 8'hE8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_idx
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
    ,
    output logic [(1<<N_IN)-1:0] obs_table
`endif
);

    localparam int NV = vec_count(N_IN);
    localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);

    sweep_state_t    state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN:0]   err_q, err_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffi_q, ffi_d;
    logic            tmr_load, tmr_en, tmr_zero;
    logic            mismatch;
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
    logic [NV-1:0]   obs_q, obs_d;
`endif

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .en   (tmr_en),
        .zero (tmr_zero)
    );

    assign mismatch = (dut_out != EXPECT[idx_q]);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffi_d    = ffi_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
        obs_d    = obs_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    err_d    = '0;
                    ffv_d    = 1'b0;
                    ffi_d    = '0;
                    tmr_load = 1'b1;
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
                    obs_d    = '0;
`endif
                end
            end
            RUN: begin
                if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else begin
                    if (mismatch) begin
                        err_d = err_q + (N_IN+1)'(1);
                    end
                    // Only the lowest failing index is kept.
                    if (mismatch && !ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
                    obs_d[idx_q] = dut_out;
`endif
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d    = idx_q + N_IN'(1);
                        tmr_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffi_q   <= ffi_d;
        end
    end

`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obs_q <= '0;
        end else begin
            obs_q <= obs_d;
        end
    end

    assign obs_table = obs_q;
`endif

    // The sweep index register is the stimulus itself.
    assign dut_in           = idx_q;
    assign busy             = (state_q == RUN);
    assign done             = (state_q == DONE);
    assign pass             = done && (err_q == '0);
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: majority/stuck DUTs on SETTLE=1, delayed DUT on SETTLE=3 and 0.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] st  = 3'b000;
    int         mode = 0;
    int         checks = 0;
    int         errors = 0;

    logic [2:0] a_in, b_in, c_in;
    logic       a_out, b_out, c_out;
    logic [2:0] b_d1 = '0, b_d2 = '0, c_d1 = '0, c_d2 = '0;
    logic [2:0] busy_v, done_v, pass_v, ffv_v;
    logic [3:0] a_err, b_err, c_err;
    logic [2:0] a_ffi, b_ffi, c_ffi;
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
    logic [7:0] a_obs, b_obs, c_obs;
`endif

    always #5 clk = ~clk;

    function automatic logic maj(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_comb begin
        a_out = maj(a_in);
        if (mode == 1) a_out = 1'b0;
        if (mode == 2) a_out = 1'b1;
    end

    // Slow DUT: output follows its input two clocks late.
    always @(posedge clk) begin
        b_d1 <= b_in;
        b_d2 <= b_d1;
        c_d1 <= c_in;
        c_d2 <= c_d1;
    end
    assign b_out = maj(b_d2);
    assign c_out = maj(c_d2);

    truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECT(8'hE8)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .dut_in(a_in), .dut_out(a_out),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(a_err), .first_fail_valid(ffv_v[0]), .first_fail_idx(a_ffi)
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
        , .obs_table(a_obs)
`endif
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(3), .EXPECT(8'hE8)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .dut_in(b_in), .dut_out(b_out),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(b_err), .first_fail_valid(ffv_v[1]), .first_fail_idx(b_ffi)
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
        , .obs_table(b_obs)
`endif
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(0), .EXPECT(8'hE8)) u_c (
        .clk(clk), .rst(rst), .start(st[2]), .dut_in(c_in), .dut_out(c_out),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(c_err), .first_fail_valid(ffv_v[2]), .first_fail_idx(c_ffi)
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
        , .obs_table(c_obs)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start on instance w and count edges after the accept edge.
    task automatic sweep(input int w, output int cyc);
        @(posedge clk); #1 st[w] = 1'b1;
        @(posedge clk); #1 st[w] = 1'b0;
        cyc = 0;
        while (!done_v[w] && cyc < 200) begin
            @(posedge clk); #1 cyc++;
        end
        check("done_seen", {31'd0, done_v[w]}, 32'd1);
    endtask

    int  cyc;
    bit  saw_done;

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_dut_in", {29'd0, a_in}, 32'd0);
        check("rst_busy", {29'd0, busy_v}, 32'd0);
        check("rst_done", {29'd0, done_v}, 32'd0);
        check("rst_pass", {29'd0, pass_v}, 32'd0);
        check("rst_err", {28'd0, a_err}, 32'd0);
        check("rst_ffv", {29'd0, ffv_v}, 32'd0);
        check("rst_ffi", {29'd0, a_ffi}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Correct majority DUT
        mode = 0;
        sweep(0, cyc);
        check("maj_cycles", cyc, 32'd16);
        check("maj_pass", {31'd0, pass_v[0]}, 32'd1);
        check("maj_err", {28'd0, a_err}, 32'd0);
        check("maj_ffv", {31'd0, ffv_v[0]}, 32'd0);
        check("maj_busy", {31'd0, busy_v[0]}, 32'd0);
        check("maj_dut_in_hold", {29'd0, a_in}, 32'd7);
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
        check("maj_obs", {24'd0, a_obs}, 32'hE8);
`endif

        // Stuck-at-0 with stimulus sequence check
        mode = 1;
        @(posedge clk); #1 st[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("s0_dut_in", {29'd0, a_in}, k / 2);
            check("s0_busy", {31'd0, busy_v[0]}, 32'd1);
            @(posedge clk); #1;
        end
        check("s0_done", {31'd0, done_v[0]}, 32'd1);
        check("s0_err", {28'd0, a_err}, 32'd4);
        check("s0_ffi", {29'd0, a_ffi}, 32'd3);
        check("s0_ffv", {31'd0, ffv_v[0]}, 32'd1);
        check("s0_pass", {31'd0, pass_v[0]}, 32'd0);

        // Stuck-at-1
        mode = 2;
        sweep(0, cyc);
        check("s1_err", {28'd0, a_err}, 32'd4);
        check("s1_ffi", {29'd0, a_ffi}, 32'd0);
        check("s1_ffv", {31'd0, ffv_v[0]}, 32'd1);
`ifdef TRUTH_TABLE_SWEEPER_LOG_EN
        check("s1_obs", {24'd0, a_obs}, 32'hFF);
`endif

        // start held high: ignored in RUN, restarts after one DONE cycle
        mode = 1;
        @(posedge clk); #1 st[0] = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            check("hold_busy", {31'd0, busy_v[0]}, 32'd1);
        end
        @(posedge clk); #1;
        check("hold_done1", {31'd0, done_v[0]}, 32'd1);
        check("hold_err1", {28'd0, a_err}, 32'd4);
        @(posedge clk); #1;
        check("hold_restart_busy", {31'd0, busy_v[0]}, 32'd1);
        check("hold_restart_done", {31'd0, done_v[0]}, 32'd0);
        check("hold_restart_err", {28'd0, a_err}, 32'd0);
        check("hold_restart_ffv", {31'd0, ffv_v[0]}, 32'd0);
        repeat (16) @(posedge clk);
        #1 st[0] = 1'b0;
        check("hold_done2", {31'd0, done_v[0]}, 32'd1);
        check("hold_err2", {28'd0, a_err}, 32'd4);
        check("hold_ffi2", {29'd0, a_ffi}, 32'd3);
        @(posedge clk); #1;
        check("hold_stays_done", {31'd0, done_v[0]}, 32'd1);

        // Asynchronous reset mid-sweep
        @(posedge clk); #1 st[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_dut_in", {29'd0, a_in}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_v[0]}, 32'd0);
        check("mid_rst_done", {31'd0, done_v[0]}, 32'd0);
        check("mid_rst_err", {28'd0, a_err}, 32'd0);
        check("mid_rst_ffv", {31'd0, ffv_v[0]}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_v[0] || busy_v[0]) saw_done = 1'b1;
        end
        check("mid_rst_no_done", {31'd0, saw_done}, 32'd0);
        mode = 0;
        sweep(0, cyc);
        check("post_rst_cycles", cyc, 32'd16);
        check("post_rst_pass", {31'd0, pass_v[0]}, 32'd1);
        check("post_rst_err", {28'd0, a_err}, 32'd0);

        // Slow DUT with SETTLE=3 passes
        sweep(1, cyc);
        check("slow3_cycles", cyc, 32'd32);
        check("slow3_pass", {31'd0, pass_v[1]}, 32'd1);
        check("slow3_err", {28'd0, b_err}, 32'd0);

        // Slow DUT with SETTLE=0 samples stale values
        sweep(2, cyc);
        check("slow0_cycles", cyc, 32'd8);
        check("slow0_err", {28'd0, c_err}, 32'd2);
        check("slow0_ffi", {29'd0, c_ffi}, 32'd3);
        check("slow0_ffv", {31'd0, ffv_v[2]}, 32'd1);
        check("slow0_pass", {31'd0, pass_v[2]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Synthesizable upstream stimulus and downstream response stage for small combinational lab circuits.
- Drives every input combination of an N_IN-input DUT in ascending order and waits a fixed settle time per vector.
- Samples the DUT's single output and compares it against an expected truth table held in a parameter.
- Reports mismatch count, first failing index, and pass/done status.
- Replaces hand-written exhaustive $display benches with a clocked self-checking stage usable on hardware.

Parameters:
- N_IN, 3: DUT input width; 2**N_IN vectors are swept.
- SETTLE, 1: idle cycles between driving a vector and sampling it; 0 is legal.
- EXPECT, 8'hE8: expected truth table, width 2**N_IN; bit i is the required dut_out for dut_in == i.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- dut_in  out  N_IN  registered stimulus to the DUT; bit 0 = A, bit 1 = B, bit 2 = C.
- dut_out  in  1  DUT response; must be combinational from dut_in.
- busy  out  1  high while sweeping.
- done  out  1  high from sweep completion until the next accepted start or rst.
- pass  out  1  done && err_count == 0.
- err_count  out  N_IN+1  number of mismatching vectors in the last sweep.
- first_fail_valid  out  1  at least one mismatch recorded.
- first_fail_idx  out  N_IN  lowest failing index; valid only when first_fail_valid = 1.

Behaviour:
- Reset values:
  - State = IDLE.
  - dut_in, busy, done, pass, err_count, first_fail_valid, first_fail_idx = 0.
  - Internal idx and settle counter = 0.
- States:
  - IDLE: waiting for start.
  - RUN: counting settle cycles, then sampling.
  - DONE: results held.
- IDLE/DONE --start--> RUN. On the accepting edge:
  - idx <= 0, dut_in <= 0, settle counter <= SETTLE.
  - err_count, first_fail_valid, first_fail_idx, done, pass cleared.
  - busy <= 1.
- RUN, settle counter != 0:
  - Decrement the counter.
  - dut_in stays stable.
- RUN, settle counter == 0 (sample edge):
  - If dut_out != EXPECT[idx]: err_count++.
  - On the first mismatch only: first_fail_idx <= idx and first_fail_valid <= 1.
  - If idx == 2**N_IN-1, go to DONE: busy <= 0, done <= 1, pass <= (final err_count == 0).
  - Otherwise: idx++, dut_in <= idx+1, counter reloaded with SETTLE.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - Accept edge is edge 0; vector i is sampled at edge (i+1)*(SETTLE+1).
  - done rises after edge 2**N_IN*(SETTLE+1). With the defaults this is 16.
- start while in RUN is ignored.
- start in DONE restarts immediately, with the same clearing as from IDLE.
- DONE holds dut_in at 2**N_IN-1 and holds all results.
- err_count width N_IN+1 holds the maximum value 2**N_IN. No saturation logic is required.
- rst asserted mid-sweep:
  - All outputs and state return to reset values immediately, without waiting for a clock edge.
  - The partial sweep is discarded and done never rises for it.
  - After rst is released, start is required again.

Optional Feature:
- Macro: TRUTH_TABLE_SWEEPER_LOG_EN.
- Defined:
  - Adds output port obs_table, width 2**N_IN, reset 0.
  - Bit idx is written with dut_out at each sample edge.
  - The whole register is cleared on an accepted start.
  - After done, obs_table holds the DUT's measured truth table.
- Undefined:
  - Port and register are absent.
  - All other behaviour is identical.

Decomposition:
- Package sweep_pkg:
  - sweep_state_t enum {IDLE, RUN, DONE}.
  - Localparam helper for vector count 2**N_IN, with N_IN passed as a function argument.
- Sub-module sweep_settle_timer:
  - Loadable down-counter of width clog2(SETTLE+1), minimum 1.
  - Inputs: load, en. Output: zero.
  - Instantiated once. Everything else stays in the top module.

Test Plan:
- Correct 3-input majority DUT, defaults, start pulse:
  - done rises exactly 16 cycles after the accept edge.
  - pass = 1, err_count = 0, first_fail_valid = 0.
- DUT stuck-at-0:
  - err_count = 4, first_fail_idx = 3, first_fail_valid = 1, pass = 0.
  - dut_in sequence 0..7, each value held 2 cycles.
- start held high continuously:
  - Ignored during RUN; sweep completes at cycle 16.
  - One DONE cycle, then restart with results cleared.
  - The second sweep produces identical results.
- rst asserted at cycle 7 for one cycle:
  - All outputs 0 immediately; no done.
  - A fresh start yields a full 16-cycle sweep with correct results.
- SETTLE = 3, DUT toggling dut_out only 2 cycles after a dut_in change:
  - pass = 1 with done at cycle 32.
  - With SETTLE = 0, mismatches are reported.
- TRUTH_TABLE_SWEEPER_LOG_EN defined, majority DUT:
  - obs_table = 8'hE8 at done.
  - Stuck-at-1 DUT gives obs_table = 8'hFF and err_count = 4.
